// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer-side signals of uart_tx_arbiter; master is the arbiter's view.
// i_req_last exists only when UART_TX_ARB_PACKET_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_byte;
`ifdef UART_TX_ARB_PACKET_EN
  logic [NUM_REQ-1:0]   i_req_last;
`endif
  logic [NUM_REQ-1:0]   o_req_ack;
  logic [NUM_REQ-1:0]   o_req_done;
  logic                 o_tx_dv;
  logic [7:0]           o_tx_byte;
  logic                 i_tx_active;
  logic                 i_tx_done;
  logic                 o_busy;
  logic [ID_W-1:0]      o_grant_id;
  logic                 o_timeout;

`ifdef UART_TX_ARB_PACKET_EN
  modport master (
    input  i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    output o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
  modport slave (
    output i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    input  o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
`else
  modport master (
    input  i_req_valid, i_req_byte, i_tx_active, i_tx_done,
    output o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
  modport slave (
    output i_req_valid, i_req_byte, i_tx_active, i_tx_done,
    input  o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_grant_id, o_timeout
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with a done watchdog.
// Define UART_TX_ARB_PACKET_EN to lock the grant to one requester until a byte marked last.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5208
) (
  input logic               i_clk,
  input logic               i_rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWaitDone, StFlush} state_e;

  state_e              state_q;
  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic                tx_dv_q, timeout_q;
  logic [NUM_REQ-1:0]  ack_q, done_q, cand;
  logic [7:0]          tx_byte_q;
  logic [ID_W-1:0]     grant_q, last_q;
  logic [CntW-1:0]     cnt_q;
  logic                hi_found, lo_found, win_found;
  logic [ID_W-1:0]     hi_id, lo_id, win_id;
  logic [7:0]          hi_byte, lo_byte, win_byte;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

`ifdef UART_TX_ARB_PACKET_EN
  logic lock_q, pkt_last_q;
  assign cand = lock_q ? (bus.i_req_valid & (NUM_REQ'(1) << grant_q)) : bus.i_req_valid;
`else
  assign cand = bus.i_req_valid;
`endif

  // Lowest candidate above last wins; otherwise wrap to the lowest candidate overall.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    hi_byte  = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    lo_byte  = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (cand[k]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(k);
        lo_byte  = bus.i_req_byte[8*k +: 8];
        if (k > int'(last_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(k);
          hi_byte  = bus.i_req_byte[8*k +: 8];
        end
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
    win_byte  = hi_found ? hi_byte : lo_byte;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_dv_q    <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      timeout_q  <= 1'b0;
      tx_byte_q  <= '0;
      grant_q    <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      cnt_q      <= '0;
`ifdef UART_TX_ARB_PACKET_EN
      lock_q     <= 1'b0;
      pkt_last_q <= 1'b0;
`endif
    end else begin
      tx_dv_q   <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A serializer still busy from before a reset must finish first.
          if (win_found && !bus.i_tx_active) begin
            tx_dv_q   <= 1'b1;
            ack_q     <= NUM_REQ'(1) << win_id;
            tx_byte_q <= win_byte;
            grant_q   <= win_id;
            last_q    <= win_id;
            cnt_q     <= '0;
            state_q   <= StWaitDone;
`ifdef UART_TX_ARB_PACKET_EN
            lock_q     <= 1'b1;
            pkt_last_q <= bus.i_req_last[win_id];
`endif
          end
        end
        StWaitDone: begin
          if (bus.i_tx_done) begin
            done_q  <= NUM_REQ'(1) << grant_q;
            cnt_q   <= '0;
            state_q <= StIdle;
`ifdef UART_TX_ARB_PACKET_EN
            if (pkt_last_q) lock_q <= 1'b0;
`endif
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StFlush;
`ifdef UART_TX_ARB_PACKET_EN
            lock_q    <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFlush: begin
          if (!bus.i_tx_active) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_tx_dv    = tx_dv_q;
  assign bus.o_req_ack  = ack_q;
  assign bus.o_req_done = done_q;
  assign bus.o_tx_byte  = tx_byte_q;
  assign bus.o_grant_id = grant_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_busy     = (state_q != StIdle);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a behavioural uart_tx stand-in.
// Packet-lock steps run only when UART_TX_ARB_PACKET_EN is defined.
module tb_uart_tx_arbiter;
  localparam int NReq = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NReq), .ID_W(2)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NReq), .ID_W(2), .TIMEOUT_CYCLES(50)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  int   tx_delay = 0;  // 0: stand-in ignores launches, bench drives man_* instead
  int   remain = 0;
  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  logic man_active   = 1'b0;
  logic man_done     = 1'b0;

  assign bus.i_tx_active = model_active | man_active;
  assign bus.i_tx_done   = model_done | man_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (bus.o_tx_dv && tx_delay != 0) begin
      model_active <= 1'b1;
      remain       <= tx_delay;
    end else if (model_active) begin
      if (remain <= 1) begin
        model_done   <= 1'b1;
        model_active <= 1'b0;
      end
      remain <= remain - 1;
    end
  end

  logic [7:0] m_byte [NReq];
  logic [3:0] m_valid;
  int         last_m, exp_id, first, to_cnt, cyc;
  logic       flag, done_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wait_dv(input string tag, input int bound);
    int c = 0;
    while (!bus.o_tx_dv && c < bound) begin
      tick();
      c++;
    end
    chk(tag, bus.o_tx_dv, 1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c = 0;
    while (bus.o_req_done == 0 && c < bound) begin
      tick();
      c++;
    end
    chk(tag, 32'(bus.o_req_done != 0), 1);
  endtask

  task automatic apply();
    bus.i_req_valid = m_valid;
    for (int k = 0; k < NReq; k++) bus.i_req_byte[8*k +: 8] = m_byte[k];
  endtask

  // First valid index scanning last+1, last+2, ... modulo NReq.
  function automatic int ref_winner(input logic [3:0] v, input int last);
    for (int s = 1; s <= NReq; s++) if (v[(last + s) % NReq]) return (last + s) % NReq;
    return -1;
  endfunction

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_byte  = '0;
`ifdef UART_TX_ARB_PACKET_EN
    bus.i_req_last  = '1;
`endif
    tick();
    tick();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_dv", bus.o_tx_dv, 0);
    chk("rst_ack", bus.o_req_ack, 0);
    chk("rst_done", bus.o_req_done, 0);
    chk("rst_byte", bus.o_tx_byte, 0);
    chk("rst_grant", bus.o_grant_id, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Round-robin with everyone continuously valid
    tx_delay = 20;
    bus.i_req_valid = 4'hF;
    bus.i_req_byte  = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      wait_dv("rr_launch", 100);
      chk("rr_grant", bus.o_grant_id, i % 4);
      chk("rr_byte", bus.o_tx_byte, 8'h10 + i % 4);
      chk("rr_ack", bus.o_req_ack, 1 << (i % 4));
      if (i == 4) bus.i_req_valid = '0;
      tick();
    end
    wait_done("rr_done_seen", 100);
    chk("rr_done", bus.o_req_done, 4'b0001);
    tick();

    // Single byte
    tx_delay = 5;
    bus.i_req_valid = 4'b0010;
    bus.i_req_byte  = 32'h0000A500;
    tick();
    chk("single_dv", bus.o_tx_dv, 1);
    chk("single_ack", bus.o_req_ack, 4'b0010);
    chk("single_byte", bus.o_tx_byte, 8'hA5);
    chk("single_grant", bus.o_grant_id, 1);
    chk("single_busy", bus.o_busy, 1);
    bus.i_req_valid = '0;
    tick();
    chk("single_dv_pulse", bus.o_tx_dv, 0);
    cyc = 0;
    while (!bus.i_tx_done && cyc < 50) begin
      tick();
      cyc++;
    end
    tick();
    chk("single_done", bus.o_req_done, 4'b0010);
    chk("single_idle", bus.o_busy, 0);
    tick();

    // Busy guard: arbiter reset while the serializer is mid-frame
    tx_delay = 30;
    bus.i_req_valid = 4'b0001;
    bus.i_req_byte  = 32'h0000005A;
    wait_dv("guard_first", 10);
    tick();
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tx_delay = 4;
    flag = 1'b0;
    cyc = 0;
    while (bus.i_tx_active && cyc < 100) begin
      if (bus.o_tx_dv) flag = 1'b1;
      tick();
      cyc++;
    end
    chk("guard_no_launch", flag, 0);
    chk("guard_active_fell", bus.i_tx_active, 0);
    tick();
    chk("guard_launch", bus.o_tx_dv, 1);
    chk("guard_grant", bus.o_grant_id, 0);
    chk("guard_byte", bus.o_tx_byte, 8'h5A);
    bus.i_req_valid = '0;
    tick();
    wait_done("guard_done_seen", 50);
    chk("guard_done", bus.o_req_done, 4'b0001);
    tick();

    // New valid in the same cycle as tx_done
    tx_delay = 0;
    bus.i_req_valid = 4'b0001;
    bus.i_req_byte  = 32'h000000E1;
    wait_dv("sim_first", 10);
    chk("sim_grant0", bus.o_grant_id, 0);
    bus.i_req_valid = '0;
    repeat (3) tick();
    man_done = 1'b1;
    bus.i_req_valid = 4'b0100;
    bus.i_req_byte  = 32'h00770000;
    tick();
    man_done = 1'b0;
    chk("sim_done0", bus.o_req_done, 4'b0001);
    chk("sim_no_early_dv", bus.o_tx_dv, 0);
    tick();
    chk("sim_launch2", bus.o_tx_dv, 1);
    chk("sim_grant2", bus.o_grant_id, 2);
    chk("sim_byte2", bus.o_tx_byte, 8'h77);
    chk("sim_ack2", bus.o_req_ack, 4'b0100);
    bus.i_req_valid = '0;
    repeat (2) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("sim_done2", bus.o_req_done, 4'b0100);
    tick();

    // Watchdog timeout, then FLUSH until the serializer goes idle
    bus.i_req_valid = 4'b0010;
    bus.i_req_byte  = 32'h00002200;
    wait_dv("to_launch", 10);
    bus.i_req_valid = '0;
    man_active = 1'b1;
    first = -1;
    to_cnt = 0;
    done_seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.o_timeout) begin
        to_cnt++;
        if (first < 0) first = k;
      end
      if (bus.o_req_done != 0) done_seen = 1'b1;
    end
    chk("to_cycle", first, 50);
    chk("to_pulse_len", to_cnt, 1);
    chk("to_no_done", done_seen, 0);
    chk("to_flush_busy", bus.o_busy, 1);
    bus.i_req_valid = 4'b1000;
    bus.i_req_byte  = 32'h3C000000;
    flag = 1'b0;
    repeat (3) begin
      tick();
      if (bus.o_tx_dv) flag = 1'b1;
    end
    chk("flush_hold", flag, 0);
    man_active = 1'b0;
    tick();
    chk("flush_exit_dv", bus.o_tx_dv, 0);
    tick();
    chk("flush_launch", bus.o_tx_dv, 1);
    chk("flush_grant", bus.o_grant_id, 3);
    chk("flush_byte", bus.o_tx_byte, 8'h3C);
    bus.i_req_valid = '0;
    repeat (2) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("flush_done", bus.o_req_done, 4'b1000);
    tick();

`ifdef UART_TX_ARB_PACKET_EN
    // Packet lock: requester 3 sends three bytes while requester 0 waits
    tx_delay = 5;
    bus.i_req_last  = 4'b0000;
    bus.i_req_valid = 4'b1000;
    bus.i_req_byte  = 32'hC0000000;
    wait_dv("pkt_launch0", 10);
    chk("pkt_grant0", bus.o_grant_id, 3);
    chk("pkt_byte0", bus.o_tx_byte, 8'hC0);
    bus.i_req_valid = 4'b1001;
    bus.i_req_byte  = 32'hC1000055;
    tick();
    wait_dv("pkt_launch1", 100);
    chk("pkt_grant1", bus.o_grant_id, 3);
    chk("pkt_byte1", bus.o_tx_byte, 8'hC1);
    bus.i_req_last  = 4'b1000;
    bus.i_req_byte  = 32'hC2000055;
    tick();
    wait_dv("pkt_launch2", 100);
    chk("pkt_grant2", bus.o_grant_id, 3);
    chk("pkt_byte2", bus.o_tx_byte, 8'hC2);
    bus.i_req_valid = 4'b0001;
    bus.i_req_last  = '1;
    tick();
    wait_dv("pkt_launch_r0", 100);
    chk("pkt_grant_r0", bus.o_grant_id, 0);
    chk("pkt_byte_r0", bus.o_tx_byte, 8'h55);
    bus.i_req_valid = '0;
    tick();
    wait_done("pkt_done_seen", 50);
    tick();
`endif

    // Randomized traffic against the scanning-rule reference
    tx_delay = 0;
    rst_n = 1'b0;
    tick();
    chk("rst2_busy", bus.o_busy, 0);
    chk("rst2_grant", bus.o_grant_id, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    last_m = NReq - 1;
    for (int k = 0; k < NReq; k++) begin
      m_valid[k] = 1'($urandom_range(0, 1));
      m_byte[k]  = 8'($urandom);
    end
    for (int t = 0; t < 24; t++) begin
      if (m_valid == 0) m_valid[$urandom_range(0, NReq - 1)] = 1'b1;
      apply();
      tx_delay = $urandom_range(1, 6);
      exp_id = ref_winner(m_valid, last_m);
      wait_dv("rand_launch", 20);
      chk("rand_grant", bus.o_grant_id, exp_id);
      chk("rand_byte", bus.o_tx_byte, m_byte[exp_id]);
      chk("rand_ack", bus.o_req_ack, 1 << exp_id);
      last_m = exp_id;
      m_byte[exp_id]  = 8'($urandom);
      m_valid[exp_id] = 1'($urandom_range(0, 1));
      for (int k = 0; k < NReq; k++) begin
        if (k != exp_id) begin
          if (m_valid[k]) begin
            if ($urandom_range(0, 3) == 0) m_valid[k] = 1'b0;
          end else if ($urandom_range(0, 1) == 1) begin
            m_valid[k] = 1'b1;
            m_byte[k]  = 8'($urandom);
          end
        end
      end
      apply();
      tick();
      wait_done("rand_done_seen", 20);
      chk("rand_done", bus.o_req_done, 1 << exp_id);
    end
    bus.i_req_valid = '0;
    repeat (3) tick();
    chk("final_idle", bus.o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
